piso_sel_ctrl: RTL

Parallel-in, serial-out controller that sits directly upstream of the 8:1 select mux. It accepts a byte over a ready/valid handshake and holds it in a register. It then steps the 3-bit select through all eight bit positions, presenting each selected bit on a serial ready/valid output. An optional even-parity bit can be appended after the data bits.

---
 rtl/piso_sel_ctrl_if.sv | 24 ++
 rtl/piso_sel_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/piso_sel_ctrl_if.sv
// Bus bundle for piso_sel_ctrl: parallel byte load handshake, serial bit
// handshake, mux select and status. dbg_state mirrors the controller FSM.
interface piso_sel_ctrl_if;
  logic [7:0] i;
  logic       i_valid;
  logic       i_ready;
  logic [2:0] s;
  logic       o;
  logic       o_valid;
  logic       o_ready;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  modport slave (
    input  i, i_valid, o_ready,
    output i_ready, s, o, o_valid, busy, done, dbg_state
  );

  modport master (
    output i, i_valid, o_ready,
    input  i_ready, s, o, o_valid, busy, done, dbg_state
  );
endinterface

// File: rtl/piso_sel_ctrl.sv
// Parallel-in serial-out controller: captures a byte, then walks the 3-bit
// mux select across all bit positions, optionally appending even parity.
module piso_sel_ctrl #(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  piso_sel_ctrl_if.slave bus
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, and ready never depends on valid.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_PAR = 2'd2} state_t;

  localparam logic [2:0] S_START = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] S_LAST  = MSB_FIRST ? 3'd0 : 3'd7;

  state_t     r_state;
  logic [7:0] r_data;
  logic       r_par;
  logic [2:0] r_s;
  logic       r_done;

  state_t     w_next_state;
  logic [2:0] w_next_s;
  logic       w_next_done;
  logic       w_load;
  logic       w_xfer;
  logic       w_o_valid;

  assign w_o_valid = (r_state == ST_DATA) || (r_state == ST_PAR);
  assign w_load    = (r_state == ST_IDLE) && bus.i_valid;
  assign w_xfer    = w_o_valid && bus.o_ready;

  assign bus.i_ready   = (r_state == ST_IDLE) && !rst;
  assign bus.o_valid   = w_o_valid;
  assign bus.busy      = w_o_valid;
  assign bus.s         = r_s;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;
  assign bus.o         = (r_state == ST_DATA) ? r_data[r_s] :
                         (r_state == ST_PAR)  ? r_par       : 1'b0;

  always_comb begin
    w_next_state = r_state;
    w_next_s     = r_s;
    w_next_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_s = S_START;
        if (w_load) w_next_state = ST_DATA;
      end
      ST_DATA: begin
        if (w_xfer) begin
          if (r_s == S_LAST) begin
            // Parity keeps s parked on the last index while it is sent.
            if (PARITY_EN) begin
              w_next_state = ST_PAR;
            end else begin
              w_next_state = ST_IDLE;
              w_next_s     = S_START;
              w_next_done  = 1'b1;
            end
          end else begin
            w_next_s = MSB_FIRST ? (r_s - 3'd1) : (r_s + 3'd1);
          end
        end
      end
      ST_PAR: begin
        if (w_xfer) begin
          w_next_state = ST_IDLE;
          w_next_s     = S_START;
          w_next_done  = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_s     = S_START;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= S_START;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_s     <= w_next_s;
      r_done  <= w_next_done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= 8'h00;
      r_par  <= 1'b0;
    end else if (w_load) begin
      r_data <= bus.i;
      r_par  <= ^bus.i;
    end
  end

endmodule
